// File: rtl/clock_set_ctrl_pkg.sv
// Shared state codes, field encodings and helpers for the clock set sequencer.
// State codes are plain localparams so legacy netlists can compare raw values.
package clock_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t RUN   = 3'd0;
  localparam state_t T_DAY = 3'd1;
  localparam state_t T_HR  = 3'd2;
  localparam state_t T_MIN = 3'd3;
  localparam state_t A_HR  = 3'd4;
  localparam state_t A_MIN = 3'd5;

  localparam logic [2:0] FLD_DAY  = 3'b100;
  localparam logic [2:0] FLD_HR   = 3'b010;
  localparam logic [2:0] FLD_MIN  = 3'b001;
  localparam logic [2:0] FLD_NONE = 3'b000;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  function automatic state_t next_state(input state_t s);
    state_t n;
    case (s)
      RUN:     n = T_DAY;
      T_DAY:   n = T_HR;
      T_HR:    n = T_MIN;
      T_MIN:   n = A_HR;
      A_HR:    n = A_MIN;
      default: n = RUN;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] field_of(input state_t s);
    logic [2:0] f;
    case (s)
      T_DAY:        f = FLD_DAY;
      T_HR, A_HR:   f = FLD_HR;
      T_MIN, A_MIN: f = FLD_MIN;
      default:      f = FLD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Front-panel buttons in, datapath set-control levels and advance strobes out.
interface clock_set_ctrl_if;
  logic       mode;
  logic       adv;
  logic       timeset;
  logic       alarmset;
  logic       dayadv;
  logic       hrsadv;
  logic       minadv;
  logic [2:0] field;

  modport master (
    output mode, adv,
    input  timeset, alarmset, dayadv, hrsadv, minadv, field
  );

  modport slave (
    input  mode, adv,
    output timeset, alarmset, dayadv, hrsadv, minadv, field
  );
endinterface

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Button edge detect with press-and-hold auto-repeat; strobe is registered.
// clr drops any repeat in progress so only a fresh press restarts it.
module btn_repeat
  import clock_ctrl_pkg::*;
#(
  parameter int HOLD = 8,
  parameter int RPT  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic clr,
  output logic press,
  output logic strobe
);

  localparam int CW = cnt_width(HOLD, RPT);

  logic          btn_q;
  logic          active;
  logic [CW-1:0] cnt;

  assign press = btn & ~btn_q;

  // cnt counts down to the next repeat strobe; it reloads rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q  <= 1'b0;
      active <= 1'b0;
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      btn_q  <= btn;
      strobe <= 1'b0;
      if (clr || !btn) begin
        active <= 1'b0;
        cnt    <= '0;
      end else if (press) begin
        active <= 1'b1;
        strobe <= 1'b1;
        cnt    <= CW'(HOLD - 1);
      end else if (active) begin
        if (cnt == '0) begin
          strobe <= 1'b1;
          cnt    <= CW'(RPT - 1);
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/Adv two-button sequencer driving the alarm-clock datapath set controls.
//   state | meaning
//   RUN   | normal timekeeping, buttons other than Mode ignored
//   T_DAY | setting time, day field
//   T_HR  | setting time, hour field
//   T_MIN | setting time, minute field
//   A_HR  | setting alarm, hour field
//   A_MIN | setting alarm, minute field
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int HOLD    = 8,
  parameter int RPT     = 2,
  parameter int TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst_n,
  clock_set_ctrl_if.slave bus
);

  localparam int CW = cnt_width(HOLD, TIMEOUT);

  state_t        state;
  state_t        state_nxt;
  logic          mode_q;
  logic          mode_press;
  logic          in_set;
  logic          activity;
  logic          timeout;
  logic          rpt_clr;
  logic          adv_press;
  logic          adv_strobe;
  logic [CW-1:0] idle;

  assign mode_press = bus.mode & ~mode_q;
  assign in_set     = (state != RUN);
  assign activity   = bus.mode | bus.adv | adv_press;
  assign timeout    = in_set && (idle == '0) && !activity;
  // Mode wins over Adv, and nothing repeats outside a set state
  assign rpt_clr    = mode_press | timeout | ~in_set;

  always_comb begin
    state_nxt = state;
    if (mode_press) begin
      state_nxt = next_state(state);
    end else if (timeout) begin
      state_nxt = RUN;
    end
  end

  // idle counts down from TIMEOUT-1; reaching zero with no activity forces RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      mode_q <= 1'b0;
      idle   <= CW'(TIMEOUT - 1);
    end else begin
      state  <= state_nxt;
      mode_q <= bus.mode;
      if (!in_set || activity) begin
        idle <= CW'(TIMEOUT - 1);
      end else if (idle != '0) begin
        idle <= idle - CW'(1);
      end
    end
  end

  btn_repeat #(
    .HOLD (HOLD),
    .RPT  (RPT)
  ) u_adv (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (bus.adv),
    .clr    (rpt_clr),
    .press  (adv_press),
    .strobe (adv_strobe)
  );

  assign bus.timeset  = (state == T_DAY) || (state == T_HR) || (state == T_MIN);
  assign bus.alarmset = (state == A_HR) || (state == A_MIN);
  assign bus.field    = field_of(state);
  assign bus.dayadv   = adv_strobe && (state == T_DAY);
  assign bus.hrsadv   = adv_strobe && ((state == T_HR) || (state == A_HR));
  assign bus.minadv   = adv_strobe && ((state == T_MIN) || (state == A_MIN));

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

- Two-button mode/set sequencer for the alarm-clock datapath (`struct_diag`).
- Converts a Mode button and an Adv button into the datapath's set-control levels (Timeset, Alarmset) and single-cycle advance strobes (Dayadv, Hrsadv, Minadv).
- Provides press-and-hold auto-repeat and an inactivity timeout back to run mode.
- Sits between the debounced front-panel inputs and the clock datapath; outputs drive the datapath ports directly.

## Interface
- HOLD, 8: cycles Adv must stay held after the press strobe before auto-repeat starts (≥2).
- RPT, 2: cycles between auto-repeat strobes (≥1).
- TIMEOUT, 64: idle cycles in any set state before forced return to RUN (≥2).
- Clk  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Mode  in  1  debounced Mode button, synchronous to Clk, high = pressed.
- Adv  in  1  debounced Advance button, synchronous to Clk, high = pressed.
- Timeset  out  1  high in T_DAY/T_HR/T_MIN.
- Alarmset  out  1  high in A_HR/A_MIN.
- Dayadv  out  1  one-cycle advance strobe for the day field.
- Hrsadv  out  1  one-cycle advance strobe for the hour field.
- Minadv  out  1  one-cycle advance strobe for the minute field.
- Field  out  3  one-hot field being edited: {day,hr,min}; 3'b000 in RUN; drives display blink.

## Operation
- States and cycle order on a Mode press: RUN → T_DAY → T_HR → T_MIN → A_HR → A_MIN → RUN.
- Press detection: a press is registered at an edge where the input is 1 and its registered previous value is 0. Releases are never acted on.
- Adv press in a set state:
  - One strobe on the current state's field output.
  - Adv in RUN is ignored: no strobe, no state change.
- Auto-repeat:
  - Adv held continuously after a press produces further strobes HOLD cycles after the press strobe, then every RPT cycles.
  - Releasing Adv clears the hold counter.
- At most one of Dayadv/Hrsadv/Minadv is high in any cycle. Strobes are never asserted in RUN.
- Simultaneous Mode press and Adv press (or Adv held): Mode wins. The state advances, no strobe is issued that cycle, and the hold counter clears. Repeat resumes only after a fresh Adv press.
- Timeout:
  - The idle counter clears on any cycle with Mode=1 or Adv=1, and counts otherwise while in a set state.
  - When it reaches TIMEOUT−1, the next edge forces RUN.
  - The counter is held at 0 in RUN.
- Reset asserted (low), including mid-edit or mid-repeat: state = RUN and all outputs = 0 immediately. Edge-detect history registers reset to 0, so a button already held at reset release registers as a press on the first edge.

## Timing
- Reset values: Timeset=0, Alarmset=0, Dayadv=0, Hrsadv=0, Minadv=0, Field=3'b000.
- Mode press sampled at edge k: state, Timeset/Alarmset and Field take their new values immediately after edge k. All outputs are registered or decoded only from registers.
- Adv press sampled at edge k: strobe high for exactly the cycle between edge k and edge k+1.
- Held Adv: strobes after edges k, k+HOLD, k+HOLD+RPT, k+HOLD+2·RPT, … Each strobe lasts one cycle.
- Timeout: last activity at edge j → RUN after edge j+TIMEOUT.
- Counter widths: $clog2(max(HOLD,TIMEOUT)+1) bits, unsigned; saturate, never wrap.

## Structure
- Package `clock_ctrl_pkg`:
  - state enum (RUN, T_DAY, T_HR, T_MIN, A_HR, A_MIN);
  - Field one-hot constants (FLD_DAY=3'b100, FLD_HR=3'b010, FLD_MIN=3'b001, FLD_NONE=3'b000).
- Sub-module `btn_repeat`:
  - parameters HOLD, RPT;
  - performs edge detection plus hold/repeat counting;
  - outputs one-cycle `press` and `strobe`;
  - synchronous `clr` input (used for Mode-wins and leaving a set state).
- Mode edge detection is inline in the top level.

## Test plan
- Reset low mid-repeat in T_MIN → all outputs 0 at once; after release, state RUN and Field=000.
- Five Mode presses from RUN → Field sequence 100,010,001,010,001. Timeset=1 for the first three, Alarmset=1 for the last two. Sixth press → RUN, both 0.
- T_HR, Adv held 20 cycles (HOLD=8, RPT=2) → Hrsadv strobes at cycle offsets 0,8,10,12,14,16,18: exactly 7 strobes, none on Dayadv or Minadv.
- RUN, Adv pulsed 10 times → no strobes, Field stays 000.
- T_DAY, Mode and Adv pressed the same edge → state T_HR, no Dayadv or Hrsadv strobe. Adv still held → no strobes until released and re-pressed.
- A_MIN, idle 63 cycles → still A_MIN. 64th idle edge → RUN, Alarmset=0. An Adv press at idle cycle 40 restarts the count.
